// File: rtl/hazard3_cdc_req_ctrl.sv
// Source-side four-phase req/ack CDC controller with a resynchronised acknowledge.
// Holds the outgoing word stable across the handshake and returns the far-side response.

module hazard3_sync_1bit #(
  parameter int unsigned N_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [N_STAGES-1:0] sync_q;

  // Plain shift chain; the first flop is the only one allowed to go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[N_STAGES-1];

endmodule

module hazard3_cdc_req_ctrl #(
  parameter int unsigned W_DATA   = 32,
  parameter int unsigned W_RESP   = 32,
  parameter int unsigned N_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              src_valid,
  output logic              src_ready,
  input  logic [W_DATA-1:0] src_data,

  output logic              resp_valid,
  output logic [W_RESP-1:0] resp_data,
  output logic              busy,

  output logic              req_out,
  output logic [W_DATA-1:0] data_out,
  input  logic              ack_in,
  input  logic [W_RESP-1:0] rdata_in
);

  if (N_STAGES < 2) begin : g_bad_stages
    $error("hazard3_cdc_req_ctrl: N_STAGES must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ_HI = 2'd1,
    S_REQ_LO = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic [W_DATA-1:0]   data_q, data_d;
  logic [W_RESP-1:0]   resp_data_q, resp_data_d;
  logic                resp_valid_q, resp_valid_d;
  logic                ack_s;
  logic                src_ready_c;

  hazard3_sync_1bit #(
    .N_STAGES (N_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ack_in),
    .q_o   (ack_s)
  );

  // A stale acknowledge left high in IDLE blocks new requests until it clears.
  assign src_ready_c = (state_q == S_IDLE) && !ack_s;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    data_d       = data_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (src_valid && src_ready_c) begin
          data_d  = src_data;
          req_d   = 1'b1;
          state_d = S_REQ_HI;
        end
      end
      S_REQ_HI: begin
        if (ack_s) begin
          resp_data_d  = rdata_in;
          resp_valid_d = 1'b1;
          req_d        = 1'b0;
          state_d      = S_REQ_LO;
        end
      end
      S_REQ_LO: begin
        if (!ack_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      data_q       <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      data_q       <= data_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign src_ready  = src_ready_c;
  assign busy       = (state_q != S_IDLE);
  assign req_out    = req_q;
  assign data_out   = data_q;
  assign resp_data  = resp_data_q;
  assign resp_valid = resp_valid_q;

endmodule
